hazard_control_unit: RTL

- Pipeline hazard controller for the 5-stage ARMv8 (LEGv8-subset) core, sitting directly upstream of the control-bubble mux in ID.
- It produces the Stall signal that zeroes Branch/RegWrite/MemRead/MemWrite entering ID/EX.
- It also drives PC/IF-ID write enables, flushes on branches resolved in MEM, and freezes the whole pipeline while data memory is not ready.
- It keeps saturating event counters for performance analysis.

---
 rtl/core_pkg.sv | 13 +
 rtl/hazard_control_unit_if.sv | 31 +++
 rtl/hazard_control_unit_sat_counter.sv | 16 +
 rtl/hazard_control_unit.sv | 119 +++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: register-index width, zero register and hazard FSM states.
package core_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] XZR_IDX = 5'd31;

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} hazState_e;

  // True when a used source operand names the given destination.
  function automatic logic srcHit(input logic used, input logic [REG_W-1:0] src,
                                  input logic [REG_W-1:0] dst);
    return used && (src == dst);
  endfunction
endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side hazard signals: register indices and events in, control enables/flushes out.
interface hazard_control_unit_if;
  logic                      IDEX_MemRead;
  logic [core_pkg::REG_W-1:0] IDEX_Rd;
  logic [core_pkg::REG_W-1:0] IFID_Rn;
  logic [core_pkg::REG_W-1:0] IFID_Rm;
  logic                      IFID_RnUsed;
  logic                      IFID_RmUsed;
  logic                      MEM_BranchTaken;
  logic                      EXMEM_MemAccess;
  logic                      mem_ready;
  logic                      Stall;
  logic                      PCWrite;
  logic                      IFIDWrite;
  logic                      Freeze;
  logic                      Flush_IFID;
  logic                      Flush_IDEX;
  logic                      Flush_EXMEM;

  modport master (
    output IDEX_MemRead, IDEX_Rd, IFID_Rn, IFID_Rm, IFID_RnUsed, IFID_RmUsed,
           MEM_BranchTaken, EXMEM_MemAccess, mem_ready,
    input  Stall, PCWrite, IFIDWrite, Freeze, Flush_IFID, Flush_IDEX, Flush_EXMEM
  );

  modport slave (
    input  IDEX_MemRead, IDEX_Rd, IFID_Rn, IFID_Rm, IFID_RnUsed, IFID_RmUsed,
           MEM_BranchTaken, EXMEM_MemAccess, mem_ready,
    output Stall, PCWrite, IFIDWrite, Freeze, Flush_IFID, Flush_IDEX, Flush_EXMEM
  );
endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating event counter; a clear in the same cycle as an increment wins.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             q <= '0;
    else if (clr)             q <= '0;
    else if (inc && q != '1)  q <= q + W'(1);
  end
endmodule

// File: rtl/hazard_control_unit.sv
// Load-use stall, branch flush and memory-wait freeze control for the 5-stage core,
// with saturating performance counters and a sticky memory-timeout flag.
module hazard_control_unit
  import core_pkg::*;
#(
  parameter int               CNT_W   = 16,
  parameter int               TIMEOUT = 255,
  parameter logic [REG_W-1:0] XZR     = XZR_IDX
) (
  input  logic               clk,
  input  logic               reset_n,
  hazard_control_unit_if.slave hz,
  input  logic               cnt_clear,
  output logic               mem_timeout,
  output logic [CNT_W-1:0]   stall_count,
  output logic [CNT_W-1:0]   flush_count,
  output logic [CNT_W-1:0]   wait_count
);
  localparam logic [9:0] TIMEOUT_W = 10'(TIMEOUT);

  hazState_e  state, stateNext;
  logic [9:0] waitRun, waitRunNext;
  logic       timeoutNext;
  logic       loadUse, memBusy;
  logic       stall, pcWrite, ifidWrite, freeze, flush;
  logic       incStall, incFlush, incWait;

  assign loadUse = hz.IDEX_MemRead && (hz.IDEX_Rd != XZR) &&
                   (srcHit(hz.IFID_RnUsed, hz.IFID_Rn, hz.IDEX_Rd) ||
                    srcHit(hz.IFID_RmUsed, hz.IFID_Rm, hz.IDEX_Rd));
  assign memBusy = hz.EXMEM_MemAccess && !hz.mem_ready;

  always_comb begin
    stateNext   = state;
    waitRunNext = waitRun;
    timeoutNext = mem_timeout;
    stall       = 1'b0;
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    freeze      = 1'b0;
    flush       = 1'b0;
    incStall    = 1'b0;
    incFlush    = 1'b0;
    incWait     = 1'b0;
    case (state)
      RUN: begin
        if (hz.MEM_BranchTaken) begin
          flush    = 1'b1;
          incFlush = 1'b1;
        end else if (memBusy) begin
          freeze      = 1'b1;
          pcWrite     = 1'b0;
          ifidWrite   = 1'b0;
          incWait     = 1'b1;
          waitRunNext = 10'd1;
          // A one-cycle budget is already exhausted by this first wait cycle.
          if (TIMEOUT_W <= 10'd1) timeoutNext = 1'b1;
          else                    stateNext   = MEM_WAIT;
        end else if (loadUse) begin
          stall     = 1'b1;
          pcWrite   = 1'b0;
          ifidWrite = 1'b0;
          incStall  = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!hz.mem_ready) begin
          freeze      = 1'b1;
          pcWrite     = 1'b0;
          ifidWrite   = 1'b0;
          incWait     = 1'b1;
          waitRunNext = waitRun + 10'd1;
          if (waitRunNext >= TIMEOUT_W) begin
            timeoutNext = 1'b1;
            stateNext   = RUN;
          end
        end else begin
          // Access completes now; a pending load-use still needs its bubble.
          stateNext = RUN;
          if (loadUse) begin
            stall     = 1'b1;
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            incStall  = 1'b1;
          end
        end
      end
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      waitRun     <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= stateNext;
      waitRun     <= waitRunNext;
      mem_timeout <= timeoutNext;
    end
  end

  // While in reset the pipeline is filled with NOPs.
  assign hz.Stall       = !reset_n || stall;
  assign hz.PCWrite     = reset_n && pcWrite;
  assign hz.IFIDWrite   = reset_n && ifidWrite;
  assign hz.Freeze      = reset_n && freeze;
  assign hz.Flush_IFID  = !reset_n || flush;
  assign hz.Flush_IDEX  = !reset_n || flush;
  assign hz.Flush_EXMEM = !reset_n || flush;

  sat_counter #(.W(CNT_W)) uStallCnt (.clk(clk), .reset_n(reset_n), .inc(incStall),
                                      .clr(cnt_clear), .q(stall_count));
  sat_counter #(.W(CNT_W)) uFlushCnt (.clk(clk), .reset_n(reset_n), .inc(incFlush),
                                      .clr(cnt_clear), .q(flush_count));
  sat_counter #(.W(CNT_W)) uWaitCnt  (.clk(clk), .reset_n(reset_n), .inc(incWait),
                                      .clr(cnt_clear), .q(wait_count));
endmodule
